// File: rtl/conv_pkg.sv
// Shared types and constants for the multi-layer convolution sequencer.
package conv_pkg;

    localparam int MAX_LAYERS      = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_GO,
        S_MEM_WAIT,
        S_PE_GO,
        S_PE_WAIT,
        S_FIN
    } conv_seq_state_t;

endpackage

// File: rtl/conv_layer_sel.sv
// Finds the lowest enabled layer strictly above cur_idx; cur_idx = -1 yields the first enabled layer.
module conv_layer_sel #(
    parameter int NUM_LAYERS = 2,
    parameter int LAYER_W    = 1
) (
    input  logic [NUM_LAYERS-1:0]  mask,
    input  logic signed [LAYER_W:0] cur_idx,
    output logic [LAYER_W-1:0]     next_idx,
    output logic                   has_next
);
    logic [NUM_LAYERS-1:0] cand;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_cand
        localparam logic signed [LAYER_W:0] GI_S = (LAYER_W+1)'(gi);
        assign cand[gi] = mask[gi] && (GI_S > cur_idx);
    end

    // Scan downward so the lowest candidate is the last one written.
    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                next_idx = LAYER_W'(i);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_seq_cu.sv
// Multi-layer convolution control unit: per enabled layer, memory load then PE compute.
// Optional watchdog on every wait phase is enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_seq_cu
    import conv_pkg::*;
#(
    parameter int NUM_LAYERS  = 2,
    parameter int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    input  logic [NUM_LAYERS-1:0] done_mem,
    input  logic [NUM_LAYERS-1:0] done_pe,
    output logic [NUM_LAYERS-1:0] start_mem,
    output logic [NUM_LAYERS-1:0] start_pe,
    output logic [NUM_LAYERS-1:0] wrmem_en,
    output logic                  busy,
    output logic [LAYER_W-1:0]    cur_layer,
    output logic                  done,
    output logic                  err
);
    conv_seq_state_t       state_reg;
    logic [NUM_LAYERS-1:0] mask_reg;
    logic [LAYER_W-1:0]    cur_layer_reg;
    logic [NUM_LAYERS-1:0] start_mem_reg;
    logic [NUM_LAYERS-1:0] start_pe_reg;
    logic [NUM_LAYERS-1:0] wrmem_en_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic [LAYER_W-1:0]     first_idx;
    logic                   first_has;
    logic [LAYER_W-1:0]     next_idx;
    logic                   next_has;
    logic signed [LAYER_W:0] minus_one;
    logic signed [LAYER_W:0] cur_idx_s;

    assign minus_one = '1;
    assign cur_idx_s = {1'b0, cur_layer_reg};

    conv_layer_sel #(.NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W)) u_first_sel (
        .mask     (layer_mask),
        .cur_idx  (minus_one),
        .next_idx (first_idx),
        .has_next (first_has)
    );

    conv_layer_sel #(.NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W)) u_next_sel (
        .mask     (mask_reg),
        .cur_idx  (cur_idx_s),
        .next_idx (next_idx),
        .has_next (next_has)
    );

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Outputs are registered and set on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            mask_reg      <= '0;
            cur_layer_reg <= '0;
            start_mem_reg <= '0;
            start_pe_reg  <= '0;
            wrmem_en_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            start_mem_reg <= '0;
            start_pe_reg  <= '0;
            done_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mask_reg <= layer_mask;
                        busy_reg <= 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                        err_reg  <= 1'b0;
`endif
                        if (first_has) begin
                            cur_layer_reg <= first_idx;
                            start_mem_reg <= NUM_LAYERS'(1) << first_idx;
                            state_reg     <= S_MEM_GO;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_FIN;
                        end
                    end
                end
                S_MEM_GO: begin
                    state_reg <= S_MEM_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                S_MEM_WAIT: begin
                    if (done_mem[cur_layer_reg]) begin
                        start_pe_reg <= NUM_LAYERS'(1) << cur_layer_reg;
                        wrmem_en_reg <= next_has ? (NUM_LAYERS'(1) << next_idx) : '0;
                        state_reg    <= S_PE_GO;
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYC)) begin
                        err_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                S_PE_GO: begin
                    state_reg <= S_PE_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                S_PE_WAIT: begin
                    if (done_pe[cur_layer_reg]) begin
                        wrmem_en_reg <= '0;
                        if (next_has) begin
                            cur_layer_reg <= next_idx;
                            start_mem_reg <= NUM_LAYERS'(1) << next_idx;
                            state_reg     <= S_MEM_GO;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_FIN;
                        end
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYC)) begin
                        err_reg      <= 1'b1;
                        done_reg     <= 1'b1;
                        wrmem_en_reg <= '0;
                        state_reg    <= S_FIN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                S_FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg     <= 1'b0;
                    wrmem_en_reg <= '0;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

    assign start_mem = start_mem_reg;
    assign start_pe  = start_pe_reg;
    assign wrmem_en  = wrmem_en_reg;
    assign busy      = busy_reg;
    assign cur_layer = cur_layer_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_conv_seq_cu.sv
// Scoreboard bench for conv_seq_cu (4 layers); timeout scenario changes with CONV_SEQ_TIMEOUT_EN.
module tb_conv_seq_cu;

    typedef struct {
        int         t;
        int         kind;   // 0 start_mem, 1 start_pe, 2 done
        logic [3:0] vec;
        logic [3:0] wr;
        int         cur;
        logic       err;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] layer_mask = '0;
    logic [3:0] done_mem;
    logic [3:0] done_pe;
    logic [3:0] start_mem;
    logic [3:0] start_pe;
    logic [3:0] wrmem_en;
    logic       busy;
    logic [1:0] cur_layer;
    logic       done;
    logic       err;

    logic [3:0] mem_seen = '0, pe_seen = '0;
    logic [3:0] resp_mem = '0, resp_pe = '0, pe_force = '0;
    bit         mem_en = 1'b1;
    bit         mon_en = 1'b0;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  t_start = 0;
    int  done_cnt = 0;
    ev_t sb[$];

    int         mon_kind;
    ev_t        mon_e;
    logic [3:0] mon_vec;

    assign done_mem = resp_mem;
    assign done_pe  = resp_pe | pe_force;

    conv_seq_cu #(.NUM_LAYERS(4), .TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .layer_mask (layer_mask),
        .done_mem   (done_mem),
        .done_pe    (done_pe),
        .start_mem  (start_mem),
        .start_pe   (start_pe),
        .wrmem_en   (wrmem_en),
        .busy       (busy),
        .cur_layer  (cur_layer),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Units answer with a one-cycle done pulse the cycle after their start.
    always @(negedge clk) begin
        mem_seen = start_mem;
        pe_seen  = start_pe;
    end
    always @(posedge clk) begin
        #1;
        resp_mem = mem_en ? mem_seen : 4'b0000;
        resp_pe  = pe_seen;
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            mon_kind = -1;
            mon_vec  = 4'b0000;
            if (start_mem != 0) begin mon_kind = 0; mon_vec = start_mem; end
            else if (start_pe != 0) begin mon_kind = 1; mon_vec = start_pe; end
            else if (done) mon_kind = 2;
            if (mon_kind == 2) done_cnt++;
            if (mon_kind >= 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind=%0d vec=%b t=%0d, none expected", mon_kind, mon_vec, cyc - t_start);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.t != cyc - t_start || mon_e.kind != mon_kind || mon_e.vec !== mon_vec ||
                        mon_e.wr !== wrmem_en || (mon_kind != 2 && mon_e.cur != int'(cur_layer)) ||
                        (mon_kind == 2 && mon_e.err !== err)) begin
                        errors++;
                        $display("FAIL event: got t=%0d kind=%0d vec=%b wr=%b cur=%0d err=%b, want t=%0d kind=%0d vec=%b wr=%b cur=%0d err=%b",
                                 cyc - t_start, mon_kind, mon_vec, wrmem_en, cur_layer, err,
                                 mon_e.t, mon_e.kind, mon_e.vec, mon_e.wr, mon_e.cur, mon_e.err);
                    end else begin
                        $display("event ok: t=%0d kind=%0d vec=%b wr=%b cur=%0d", mon_e.t, mon_kind, mon_vec, wrmem_en, cur_layer);
                    end
                end
            end
        end
    end

    // Expected event stream for nruns back-to-back runs of mask m.
    task automatic push_expected(input logic [3:0] m, input int nruns);
        int base = 0;
        for (int r = 0; r < nruns; r++) begin
            int k = 0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    logic [3:0] wr = 4'b0000;
                    for (int j = 3; j > i; j--) if (m[j]) wr = 4'b0001 << j;
                    sb.push_back('{t: base + 1 + 4*k, kind: 0, vec: 4'b0001 << i, wr: 4'b0000, cur: i, err: 1'b0});
                    sb.push_back('{t: base + 3 + 4*k, kind: 1, vec: 4'b0001 << i, wr: wr, cur: i, err: 1'b0});
                    k++;
                end
            end
            sb.push_back('{t: base + 1 + 4*k, kind: 2, vec: 4'b0000, wr: 4'b0000, cur: 0, err: 1'b0});
            base += 4*k + 2;
        end
    endtask

    task automatic run_seq(input logic [3:0] m, input int nruns, input bit noise, input string name);
        push_expected(m, nruns);
        layer_mask = m;
        t_start = cyc;
        done_cnt = 0;
        start = 1'b1;
        for (int k = 1; k < 200 && done_cnt < nruns; k++) begin
            @(posedge clk); #1;
            start    = (nruns > 1) || (noise && (k == 2 || k == 6));
            pe_force = (noise && (k == 3 || k == 4)) ? 4'b0010 : 4'b0000;
        end
        start = 1'b0;
        pe_force = 4'b0000;
        checks++;
        if (done_cnt != nruns) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, want %0d", name, done_cnt, nruns);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events: %0d expected events never seen", name, sb.size());
        end
        sb.delete();
        @(posedge clk); #1;
        $display("%s: mask=%b runs=%0d complete", name, m, nruns);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({start_mem, start_pe, wrmem_en, busy, cur_layer, done, err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sm=%b sp=%b wr=%b busy=%b cur=%0d done=%b err=%b, want all 0",
                     start_mem, start_pe, wrmem_en, busy, cur_layer, done, err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_two_layer;
        run_seq(4'b0011, 1, 1'b0, "two_layer");
    endtask

    task automatic test_sparse;
        run_seq(4'b1010, 1, 1'b0, "sparse");
        checks++;
        if (busy !== 1'b0 || cur_layer !== 2'd3) begin
            errors++;
            $display("FAIL sparse_idle_hold: got busy=%b cur=%0d, want busy=0 cur=3", busy, cur_layer);
        end
    endtask

    task automatic test_empty_mask;
        sb.push_back('{t: 1, kind: 2, vec: 4'b0000, wr: 4'b0000, cur: 0, err: 1'b0});
        layer_mask = 4'b0000;
        t_start = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL empty_first_cycle: got busy=%b done=%b, want 1 1", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_second_cycle: got busy=%b done=%b, want 0 0", busy, done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL empty_missing_done: %0d events left", sb.size());
        end
        sb.delete();
        $display("test_empty_mask: complete");
    endtask

    task automatic test_ignored_inputs;
        run_seq(4'b0011, 1, 1'b1, "ignored_inputs");
    endtask

    task automatic test_back_to_back;
        run_seq(4'b0001, 2, 1'b0, "back_to_back");
    endtask

    task automatic test_reset_mid_run;
        sb.push_back('{t: 1, kind: 0, vec: 4'b0001, wr: 4'b0000, cur: 0, err: 1'b0});
        sb.push_back('{t: 3, kind: 1, vec: 4'b0001, wr: 4'b0010, cur: 0, err: 1'b0});
        sb.push_back('{t: 5, kind: 0, vec: 4'b0010, wr: 4'b0000, cur: 1, err: 1'b0});
        layer_mask = 4'b0011;
        t_start = cyc;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start_mem, start_pe, wrmem_en, busy, cur_layer, done, err} !== 17'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got sm=%b sp=%b wr=%b busy=%b cur=%0d done=%b, want all 0",
                     start_mem, start_pe, wrmem_en, busy, cur_layer, done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrun_missing_events: %0d left", sb.size());
        end
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(4'b0011, 1, 1'b0, "after_reset");
    endtask

`ifdef CONV_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        mem_en = 1'b0;
        sb.push_back('{t: 1, kind: 0, vec: 4'b0001, wr: 4'b0000, cur: 0, err: 1'b0});
        sb.push_back('{t: 11, kind: 2, vec: 4'b0000, wr: 4'b0000, cur: 0, err: 1'b1});
        layer_mask = 4'b0001;
        t_start = cyc;
        done_cnt = 0;
        start = 1'b1;
        for (int k = 1; k < 40 && done_cnt < 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (done_cnt != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_done: got dones=%0d left=%0d, want 1 0", done_cnt, sb.size());
        end
        sb.delete();
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b busy=%b, want 1 0", err, busy);
        end
        mem_en = 1'b1;
        sb.push_back('{t: 1, kind: 2, vec: 4'b0000, wr: 4'b0000, cur: 0, err: 1'b0});
        layer_mask = 4'b0000;
        t_start = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b, want 0", err);
        end
        @(posedge clk); #1;
        sb.delete();
        $display("test_timeout: complete");
    endtask
`else
    task automatic test_timeout;
        mem_en = 1'b0;
        sb.push_back('{t: 1, kind: 0, vec: 4'b0001, wr: 4'b0000, cur: 0, err: 1'b0});
        layer_mask = 4'b0001;
        t_start = cyc;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL unbounded_wait: got busy=%b err=%b left=%0d, want 1 0 0", busy, err, sb.size());
        end
        sb.delete();
        rst_n = 1'b0;
        mem_en = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_timeout: unbounded wait complete");
    endtask
`endif

    initial begin
        test_reset();
        test_two_layer();
        test_sparse();
        test_empty_mask();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_run();
        test_timeout();
        run_seq(4'b1111, 1, 1'b0, "all_layers");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_seq_cu.md
Name: conv_seq_cu

Overview:
- Parametrised control unit for the multi-layer convolution engine; successor to the fixed two-layer controller.
- Sequences NUM_LAYERS layers. Each layer runs a memory-load phase, then a PE compute phase.
- Drives a one-hot start to each layer's memory and PE units and a write-enable that routes PE output into the next active layer's memory.
- Adds a runtime layer-skip mask, a busy/current-layer status and an optional watchdog.

Parameters:
- NUM_LAYERS, 2, number of conv layers sequenced (1..16).
- LAYER_W, $clog2(NUM_LAYERS) min 1, width of the current-layer index.
- TIMEOUT_CYC, 1024, watchdog limit in cycles per wait phase (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- layer_mask  in  NUM_LAYERS  bit i=1 enables layer i; latched on accepted start.
- done_mem  in  NUM_LAYERS  per-layer memory-load complete.
- done_pe  in  NUM_LAYERS  per-layer PE compute complete.
- start_mem  out  NUM_LAYERS  one-cycle one-hot start to layer memory.
- start_pe  out  NUM_LAYERS  one-cycle one-hot start to layer PE.
- wrmem_en  out  NUM_LAYERS  write enable into layer memory fed by the previous active PE.
- busy  out  1  high whenever state is not IDLE.
- cur_layer  out  LAYER_W  index of the layer in progress.
- done  out  1  one-cycle run-complete pulse.
- err  out  1  timeout flag (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; latched mask 0; cur_layer 0.
- Reset is asynchronous at any point mid-run and abandons the run. No done pulse is issued.
- States: IDLE, MEM_GO, MEM_WAIT, PE_GO, PE_WAIT, FIN.
- IDLE: on start=1, latch layer_mask.
  - mask==0: go to FIN.
  - mask!=0: cur_layer = lowest set bit; go to MEM_GO.
- MEM_GO: start_mem[cur_layer]=1 for exactly this cycle; go to MEM_WAIT.
- MEM_WAIT: hold until done_mem[cur_layer]=1; then go to PE_GO.
- PE_GO: start_pe[cur_layer]=1 for this cycle; go to PE_WAIT.
- PE_WAIT: hold until done_pe[cur_layer]=1.
  - If a higher enabled layer exists: cur_layer = next enabled index; go to MEM_GO.
  - Otherwise: go to FIN.
- FIN: done=1 for one cycle; return to IDLE.
- wrmem_en[n]=1 during PE_GO and PE_WAIT, where n = next enabled layer above cur_layer. All bits are 0 when cur_layer is the last enabled layer.
- done_* sampling:
  - Only the bit indexed by cur_layer, and only in the matching WAIT state.
  - Other bits and other states are ignored.
  - A done asserted in the GO cycle is not seen; units must assert done no earlier than the cycle after their start. Level or pulse done are both accepted.
- start while busy is ignored. start during FIN is ignored; a new start is accepted on the IDLE cycle after.
- Latency: minimum per enabled layer is 4 cycles (done in first WAIT cycle). Start-to-done = 4·k+1 cycles with k enabled layers; mask==0 gives done 1 cycle after start.
- cur_layer is valid while busy and holds its last value in IDLE.

Optional Feature:
- Macro CONV_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to MEM_WAIT/PE_WAIT and increments each wait cycle.
  - When it reaches TIMEOUT_CYC, set err=1 (sticky until the next accepted start or reset) and go to FIN. done still pulses.
- Undefined: no counter; err is tied 0; waits are unbounded.

Decomposition:
- Shared package conv_pkg holds:
  - state enum conv_seq_state_t.
  - MAX_LAYERS=16.
  - default TIMEOUT_CYC constant.
- Sub-module conv_layer_sel: combinational next-enabled-layer finder. Inputs are mask and current index; outputs are next index and a has_next flag. The same finder with index -1 gives the first layer.

Test Plan:
- NUM_LAYERS=2, mask=2'b11, done_mem/done_pe returned 1 cycle after each start.
  -> start_mem[0], start_pe[0] (wrmem_en[1] high), start_mem[1], start_pe[1] (wrmem_en 0); done 9 cycles after start.
- NUM_LAYERS=4, mask=4'b1010.
  -> only layers 1 and 3 started; wrmem_en[3] high during layer-1 PE phase; cur_layer goes 1 then 3.
- mask=0, start.
  -> done pulse 1 cycle later; no start_mem/start_pe asserted; busy high for exactly 1 cycle.
- start pulsed mid-run; done_pe[1] held high during layer-0 PE_WAIT.
  -> both ignored; sequence unchanged.
- rst_n driven low during MEM_WAIT of layer 1.
  -> all outputs 0 immediately; IDLE; a fresh start runs from the lowest enabled layer.
- CONV_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=8, done_mem never asserted.
  -> err=1 and done pulse 9 cycles after MEM_WAIT entry; err clears on the next accepted start.
